// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into low then high 16-bit SRAM accesses, each held SRAM_WAIT cycles.
// Latency 2*SRAM_WAIT+2 cycles; ready drops combinationally on request and rises in DONE to release the pipeline.
module sram_controller #(
    parameter int SRAM_WAIT = 2,
    parameter int DATA_BASE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int              CNT_W    = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);
    localparam logic [31:0]      BASE     = 32'(DATA_BASE);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op_wr;
    logic [16:0]      idx_q;
    logic [31:0]      wdata_q;

    logic        req;
    logic        last;
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign req    = rd_en | wr_en;
    assign last   = (cnt == CNT_LAST);
    assign offset = address - BASE;
    // Out-of-range addresses simply wrap onto the 2^17-word SRAM.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                end
            end
            LO: begin
                if (last) begin
                    state_nxt = HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HI: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Operands are captured once so the access is immune to later input changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req) begin
            op_wr   <= wr_en;
            idx_q   <= offset[18:2];
            wdata_q <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (!op_wr && last) begin
            if (state == LO) begin
                read_data[15:0] <= sram_dq_in;
            end else if (state == HI) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = !req;
            end
            LO: begin
                sram_addr = {idx_q, 1'b0};
                if (op_wr) begin
                    sram_dq_out = wdata_q[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            HI: begin
                sram_addr = {idx_q, 1'b1};
                if (op_wr) begin
                    sram_dq_out = wdata_q[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller with a small behavioural SRAM and a read-data scoreboard.
module tb_sram_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] sb_q[$];
    logic [31:0] ref_mem[int];
    logic [31:0] last_rd;

    logic [15:0] sram_mem[0:255];

    sram_controller #(.SRAM_WAIT(W), .DATA_BASE(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq_out;
    end
    assign sram_dq_in = sram_mem[sram_addr[7:0]];

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'd1024;
        return d[18:2];
    endfunction

    // Drives one request and checks every cycle of it; returns one cycle after DONE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd);
        logic [16:0] ix;
        logic        lo, hi, busy, exp_rdy;
        logic [17:0] exp_addr;
        logic [31:0] exp_rd;
        ix = word_idx(a);
        rd_en = rd; wr_en = wr; address = a; write_data = wd;
        if (wr) ref_mem[int'(ix)] = wd;
        else    sb_q.push_back(ref_mem[int'(ix)]);
        for (int c = 0; c <= 2*W+1; c++) begin
            @(negedge clk);
            lo      = (c >= 1) && (c <= W);
            hi      = (c > W) && (c <= 2*W);
            busy    = lo | hi;
            exp_rdy = (c == 2*W+1);
            exp_addr = lo ? {ix, 1'b0} : (hi ? {ix, 1'b1} : 18'd0);
            tests_run++;
            if (ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL ready a=%0d c=%0d got %b want %b", a, c, ready, exp_rdy);
            end
            tests_run++;
            if (sram_addr !== exp_addr) begin
                tests_failed++;
                $display("FAIL sram_addr a=%0d c=%0d got %0d want %0d", a, c, sram_addr, exp_addr);
            end
            tests_run++;
            if (sram_we_n !== !(busy && wr)) begin
                tests_failed++;
                $display("FAIL sram_we_n a=%0d c=%0d got %b want %b", a, c, sram_we_n, !(busy && wr));
            end
            tests_run++;
            if (sram_dq_oe !== (busy && wr)) begin
                tests_failed++;
                $display("FAIL sram_dq_oe a=%0d c=%0d got %b want %b", a, c, sram_dq_oe, busy && wr);
            end
            if (wr || !busy) begin
                tests_run++;
                if (sram_dq_out !== (!busy ? 16'h0 : (lo ? wd[15:0] : wd[31:16]))) begin
                    tests_failed++;
                    $display("FAIL sram_dq_out a=%0d c=%0d got %h want %h", a, c, sram_dq_out,
                             !busy ? 16'h0 : (lo ? wd[15:0] : wd[31:16]));
                end
            end
            if (c == 2*W+1) begin
                if (wr) exp_rd = last_rd;
                else    exp_rd = sb_q.pop_front();
                tests_run++;
                if (read_data !== exp_rd) begin
                    tests_failed++;
                    $display("FAIL read_data a=%0d got %h want %h", a, read_data, exp_rd);
                end
                last_rd = exp_rd;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_idle();
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; go_idle(); address = '0; write_data = '0;
        #1;
        tests_run++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got rdy=%b we_n=%b oe=%b want 1 1 0", ready, sram_we_n, sram_dq_oe);
        end
        tests_run++;
        if (sram_addr !== 18'd0 || sram_dq_out !== 16'd0 || read_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_data got addr=%0d dq=%h rd=%h want 0", sram_addr, sram_dq_out, read_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1028, 32'h0);
        go_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1100; write_data = 32'h12345678;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (sram_we_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_lo_we_n got %b want 0", sram_we_n);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_bus got we_n=%b oe=%b addr=%0d want 1 0 0", sram_we_n, sram_dq_oe, sram_addr);
        end
        tests_run++;
        if (read_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_rd got %h want 0", read_data);
        end
        go_idle();
        #1;
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_ready got %b want 1", ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        access(1'b0, 1'b1, 32'd1024, 32'h11112222);
        access(1'b0, 1'b1, 32'd1032, 32'h33334444);
        go_idle();
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        access(1'b1, 1'b0, 32'd1032, 32'h0);
        go_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        go_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
                sram_addr !== 18'd0 || sram_dq_out !== 16'd0) begin
                tests_failed++;
                $display("FAIL idle_bus cyc=%0d got rdy=%b we_n=%b oe=%b addr=%0d dq=%h", i,
                         ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out);
            end
            tests_run++;
            if (read_data !== last_rd) begin
                tests_failed++;
                $display("FAIL idle_rd cyc=%0d got %h want %h", i, read_data, last_rd);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        access(1'b1, 1'b0, 32'd1024 + 32'd4 * 32'd131072, 32'h0);
        go_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_both();
        access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D);
        go_idle();
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'd1040, 32'h0);
        go_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_mid_reset();
        test_back_to_back();
        test_idle();
        test_wrap();
        test_both();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_left got %0d want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
